// File: rtl/seg_mux_driver.sv
// seg_mux_driver: time-multiplexed driver for NDIG seven-segment digits.
//   gclk, rst      clock; asynchronous active-high reset
//   en             scan enable; when low the scan position holds and all outputs go dark
//   load           capture value/dp_in into a pending register, shown from the next frame
//   value          hex nibbles, digit k at [4k+3:4k], digit 0 least significant
//   dp_in          decimal point request per digit
//   blank_lz       suppress leading zero digits (digit 0 always shown)
//   bright         PWM on-time per slot, (bright+1)/2^DUTY_W of the slot
//   sel_digit      digit enables, active-low, at most one low
//   seg            segments {g,f,e,d,c,b,a}, active-low
//   dp             decimal point, active-low
//   frame_done     one-cycle pulse after the tick that wraps the digit index
module seg_mux_driver #(
  parameter int NDIG   = 4,
  parameter int DIV    = 200,
  parameter int DUTY_W = 3
) (
  input  logic                gclk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   value,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                blank_lz,
  input  logic [DUTY_W-1:0]   bright,
  output logic [NDIG-1:0]     sel_digit,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(NDIG);
  // Wide enough to hold both sides of the on-time comparison without overflow.
  localparam int CW = PW + DUTY_W + 1;

  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                fd_q, fd_d;
  logic                pend_flag_q, pend_flag_d;
  logic [4*NDIG-1:0]   pend_val_q, pend_val_d;
  logic [NDIG-1:0]     pend_dp_q, pend_dp_d;
  logic [4*NDIG-1:0]   act_val_q, act_val_d;
  logic [NDIG-1:0]     act_dp_q, act_dp_d;
  logic [NDIG-1:0]     sel_q, sel_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                tick, wrap;
  logic [NDIG-1:0]     blank_vec;
  logic                upper_zero;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank, lit;
  logic [CW-1:0]       on_lhs, on_rhs;
  logic [6:0]          dec;

  // Scan position and frame pulse
  always_comb begin
    tick   = en && (pcnt_q == PW'(DIV - 1));
    wrap   = tick && (idx_q == IW'(NDIG - 1));
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    fd_d = wrap;
  end

  // Display data double buffer: the active register only changes at a frame wrap.
  // A load coinciding with the wrap goes straight to the active register.
  always_comb begin
    pend_flag_d = pend_flag_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    if (wrap) begin
      if (load) begin
        act_val_d   = value;
        act_dp_d    = dp_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        act_val_d   = pend_val_q;
        act_dp_d    = pend_dp_q;
        pend_flag_d = 1'b0;
      end
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
  end

  // Leading-zero blanking: walk from the top digit down while nibbles stay zero.
  always_comb begin
    blank_vec  = '0;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NDIG - 1; i++) begin
      upper_zero = upper_zero && (act_val_q[4*(NDIG-1-i) +: 4] == 4'h0);
      blank_vec[NDIG-1-i] = blank_lz && upper_zero;
    end
  end

  // Selected digit data
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = act_val_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = blank_vec[i];
      end
    end
  end

  always_comb begin
    dec = '1;
    case (cur_nib)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000;
      4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110;
      4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110;
      4'hF: dec = 7'b0001110;
      default: dec = '1;
    endcase
  end

  // Registered outputs; segments and dp stay dark whenever no digit is enabled.
  always_comb begin
    on_lhs = CW'(pcnt_q) << DUTY_W;
    on_rhs = (CW'(bright) + CW'(1)) * CW'(DIV);
    lit    = en && !cur_blank && (on_lhs < on_rhs);
    sel_d  = '1;
    seg_d  = '1;
    dp_d   = 1'b1;
    if (lit) begin
      sel_d = ~(NDIG'(1) << idx_q);
      seg_d = dec;
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      fd_q        <= 1'b0;
      pend_flag_q <= 1'b0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      sel_q       <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
    end else begin
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      fd_q        <= fd_d;
      pend_flag_q <= pend_flag_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign sel_digit  = sel_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver with NDIG=4, DIV=8, DUTY_W=3.
module tb_seg_mux_driver;

  logic        gclk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic [3:0]  sel_digit;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  seg_mux_driver #(.NDIG(4), .DIV(8), .DUTY_W(3)) dut (
    .gclk(gclk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .bright(bright), .sel_digit(sel_digit), .seg(seg),
    .dp(dp), .frame_done(frame_done)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 100);
    chk(tag, {31'd0, frame_done}, 32'd1);
  endtask

  // Scan one frame starting just after a frame_done sample. Optionally pulse
  // load after sample ld_at (1..31). dark: digits expected never lit.
  // segs packs expected segment codes {d3,d2,d1,d0}; dps the expected dp pins.
  task automatic scan_check(input string tag, input int ld_at, input logic [15:0] ld_val,
                            input logic [3:0] ld_dp, input int on, input logic [3:0] dark,
                            input logic [27:0] segs, input logic [3:0] dps);
    int lit[4];
    logic [6:0] seg_f[4];
    logic dp_f[4];
    int fd_n = 0;
    int bad = 0;
    for (int s = 0; s < 4; s++) lit[s] = 0;
    for (int k = 1; k <= 32; k++) begin
      int s;
      logic [3:0] on_pat;
      step();
      s = (k - 1) / 8;
      on_pat = ~(4'b0001 << s);
      if (sel_digit == on_pat) lit[s]++;
      else if (sel_digit != 4'hF) bad++;
      if ((k - 1) % 8 == 0) begin
        seg_f[s] = seg;
        dp_f[s]  = dp;
      end
      if (frame_done) fd_n++;
      if (k == ld_at) begin
        load = 1'b1; value = ld_val; dp_in = ld_dp;
      end
      if (k == ld_at + 1) load = 1'b0;
    end
    chk({tag, "_fd_once"}, fd_n, 1);
    chk({tag, "_sel_ok"}, bad, 0);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s_lit%0d", tag, s), lit[s], dark[s] ? 0 : on);
      if (!dark[s]) begin
        chk($sformatf("%s_seg%0d", tag, s), {25'd0, seg_f[s]}, {25'd0, segs[7*s +: 7]});
        chk($sformatf("%s_dp%0d", tag, s), {31'd0, dp_f[s]}, {31'd0, dps[s]});
      end
    end
  endtask

  initial begin
    int n;
    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_sel", sel_digit, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    step();
    rst = 1'b0; en = 1'b1; bright = 3'd7;
    step();
    load = 1'b1; value = 16'h1234; dp_in = 4'b0101;
    step();
    load = 1'b0;
    wait_frame("wf_1234");
    // digits 0..3 = 4,3,2,1 ; dp on digits 0 and 2
    scan_check("f1234", 0, '0, '0, 8, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1010);
    // mid-frame load: this frame unchanged, next frame all A
    scan_check("fmid", 12, 16'hAAAA, 4'b0000, 8, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1010);
    blank_lz = 1'b1;
    // load coinciding with the wrap tick
    scan_check("fA", 31, 16'h0050, 4'b1000, 8, 4'b0000, {7'h08, 7'h08, 7'h08, 7'h08}, 4'b1111);
    scan_check("fblank", 0, '0, '0, 8, 4'b1100, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111);
    blank_lz = 1'b0;
    scan_check("fnoblank", 0, '0, '0, 8, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0111);
    bright = 3'd1;
    scan_check("fbr1", 0, '0, '0, 2, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0111);
    bright = 3'd0;
    scan_check("fbr0", 0, '0, '0, 1, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0111);
    bright = 3'd7;
    // Enable drop mid-slot 0 at pcnt=3
    step(); step(); step();
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sel_digit == 4'hF) n++;
    end
    chk("en_off_dark", n, 5);
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sel_digit == 4'hE) n++;
    end
    chk("en_resume_d0", n, 5);
    step();
    chk("en_resume_d1", sel_digit, 4'hD);
    // Reset mid-frame, between clock edges
    wait_frame("wf_rst");
    for (int i = 0; i < 13; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("mrst_sel", sel_digit, 4'hF);
    chk("mrst_seg", seg, 7'h7F);
    chk("mrst_dp", dp, 1'b1);
    chk("mrst_fd", frame_done, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    chk("post_sel", sel_digit, 4'hE);
    chk("post_seg", seg, 7'h40);
    chk("post_dp", dp, 1'b1);
    n = 1;
    do begin
      step();
      n++;
    end while (!frame_done && n < 100);
    chk("post_frame_len", n, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
